// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic execution units.
//   state_t        : control states of the multi-cycle divider
//   DEFAULT_WIDTH  : default operand/result width of the arithmetic blocks
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // IDLE : waiting for a request
    // RUN  : one quotient bit produced per clock
    // DONE : results valid for exactly one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_n.sv
// ---------------------------------------------------------------------------
// addsub_n
// Combinational N-bit ripple-carry adder/subtractor.
//   i_a    [N-1:0] : first operand
//   i_b    [N-1:0] : second operand
//   i_en           : mode, 0 = add (a + b), 1 = subtract (a + ~b + 1)
//   o_sum  [N-1:0] : result bits
//   o_cout         : carry out of the top bit (1 = no borrow when subtracting)
// ---------------------------------------------------------------------------
module addsub_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_en,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N-1:0] w_bx;
    logic [N:0]   w_carry;
    logic [N-1:0] w_sum;

    // Subtraction reuses the adder: invert b and inject the +1 through the
    // carry-in. The carry then ripples bit by bit through full adders.
    always_comb begin
        w_bx       = i_b ^ {N{i_en}};
        w_carry    = '0;
        w_carry[0] = i_en;
        w_sum      = '0;
        for (int k = 0; k < N; k++) begin
            w_sum[k]     = i_a[k] ^ w_bx[k] ^ w_carry[k];
            w_carry[k+1] = (i_a[k] & w_bx[k]) | (w_carry[k] & (i_a[k] ^ w_bx[k]));
        end
    end

    assign o_sum  = w_sum;
    assign o_cout = w_carry[N];

endmodule

// File: rtl/divider_seq.sv
// ---------------------------------------------------------------------------
// divider_seq
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk                     : system clock, rising edge
//   rst                     : asynchronous active-high reset
//   start                   : request, sampled only while not busy
//   dividend   [WIDTH-1:0]  : numerator, captured on the accepting edge
//   divisor    [WIDTH-1:0]  : denominator, captured on the accepting edge
//   busy                    : division in progress
//   done                    : one-cycle pulse, results valid
//   quotient   [WIDTH-1:0]  : result, held until the next accept
//   remainder  [WIDTH-1:0]  : result, held until the next accept
//   div_by_zero             : divisor was zero, held with the results
// A zero divisor skips the iteration and reports quotient = all ones,
// remainder = dividend.
// ---------------------------------------------------------------------------
module divider_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic               r_dbz;

    logic               w_accept;
    logic               w_divZero;
    logic               w_lastStep;
    logic [WIDTH:0]     w_rShift;
    logic [WIDTH:0]     w_diff;
    logic               w_cout;
    logic               w_fits;

    assign w_accept   = start && (r_state != RUN);
    assign w_divZero  = (divisor == '0);
    assign w_lastStep = (r_count == CNT_W'(WIDTH - 1));

    // The stored partial remainder is always below the divisor, so it fits
    // in WIDTH bits; the WIDTH+1 bit shifted value brings in the next
    // dividend bit from the top of the dividend shift register.
    assign w_rShift = {r_rem, r_dvd[WIDTH-1]};

    addsub_n #(
        .N (WIDTH + 1)
    ) u_trialSub (
        .i_a    (w_rShift),
        .i_b    ({1'b0, r_divisor}),
        .i_en   (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_cout)
    );

    // The shifted remainder is at least the divisor when the trial
    // difference is non-negative; carry-out and a clear sign bit both
    // express that and always agree for these operand ranges.
    assign w_fits = w_cout & ~w_diff[WIDTH];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. DONE falls back to IDLE unless a
    // new request arrives, which allows back-to-back divisions.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_nextState = w_divZero ? DONE : RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. An accept latches the operands so later input changes are
    // invisible; a zero divisor writes the final results immediately.
    // In RUN, each edge restores or keeps the trial difference and shifts
    // one quotient bit in, MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_dvd     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_dvd     <= dividend;
            r_divisor <= divisor;
            if (w_divZero) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_quot <= '0;
                r_rem  <= '0;
                r_dbz  <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_count <= r_count + CNT_W'(1);
            r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
            r_quot  <= {r_quot[WIDTH-2:0], w_fits};
            r_rem   <= w_fits ? w_diff[WIDTH-1:0] : w_rShift[WIDTH-1:0];
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_divider_seq
// Directed self-checking bench for divider_seq (WIDTH=4 plus a WIDTH=8 copy).
// ---------------------------------------------------------------------------
module tb_divider_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    logic         start8 = 1'b0;
    logic [7:0]   dividend8 = '0;
    logic [7:0]   divisor8 = '0;
    logic         busy8;
    logic         done8;
    logic [7:0]   quotient8;
    logic [7:0]   remainder8;
    logic         div_by_zero8;

    int total = 0;
    int bad = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    divider_seq #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (div_by_zero8)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and
    // outputs are sampled here, away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request to the WIDTH=4 unit.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
    endtask

    // Full division with timing checks, ending in the DONE cycle.
    task automatic runDivide(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] expQ, input logic [W-1:0] expR,
                             input logic expZ, input bit checkTiming);
        applyStimulus(a, b);
        tick;
        start = 1'b0;
        if (b != '0) begin
            for (int i = 0; i < W; i++) begin
                if (checkTiming) begin
                    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
                    checkOutput({tag, " early done"}, 32'(done), 32'd0);
                end
                tick;
            end
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
        checkOutput({tag, " quotient"}, 32'(quotient), 32'(expQ));
        checkOutput({tag, " remainder"}, 32'(remainder), 32'(expR));
        checkOutput({tag, " dbz"}, 32'(div_by_zero), 32'(expZ));
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset quotient", 32'(quotient), 32'd0);
        checkOutput("reset remainder", 32'(remainder), 32'd0);
        checkOutput("reset dbz", 32'(div_by_zero), 32'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;

        // 13/3 with cycle-accurate busy/done, then results hold.
        runDivide("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        tick;
        checkOutput("13/3 done pulse ends", 32'(done), 32'd0);
        checkOutput("13/3 idle busy", 32'(busy), 32'd0);
        checkOutput("13/3 hold q", 32'(quotient), 32'd4);
        checkOutput("13/3 hold r", 32'(remainder), 32'd1);
        tick;
        checkOutput("13/3 hold q2", 32'(quotient), 32'd4);

        runDivide("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
        runDivide("7/9", 4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 1'b1);
        runDivide("0/5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1);
        tick;
        checkOutput("0/5 done pulse ends", 32'(done), 32'd0);

        // Divide by zero: DONE immediately after the accept edge.
        runDivide("11/0", 4'd11, 4'd0, 4'hF, 4'd11, 1'b1, 1'b1);
        tick;
        checkOutput("11/0 done pulse ends", 32'(done), 32'd0);
        checkOutput("11/0 hold dbz", 32'(div_by_zero), 32'd1);

        // 9/2 with start held and new operands presented during RUN.
        applyStimulus(4'd9, 4'd2);
        tick;
        dividend = 4'd14;
        divisor  = 4'd7;
        for (int i = 0; i < W; i++) begin
            checkOutput("9/2 busy", 32'(busy), 32'd1);
            tick;
        end
        checkOutput("9/2 done", 32'(done), 32'd1);
        checkOutput("9/2 quotient", 32'(quotient), 32'd4);
        checkOutput("9/2 remainder", 32'(remainder), 32'd1);
        tick;
        checkOutput("14/7 back-to-back busy", 32'(busy), 32'd1);
        checkOutput("14/7 back-to-back done", 32'(done), 32'd0);
        start = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            tick;
        end
        checkOutput("14/7 early done", 32'(done), 32'd0);
        tick;
        checkOutput("14/7 done", 32'(done), 32'd1);
        checkOutput("14/7 quotient", 32'(quotient), 32'd2);
        checkOutput("14/7 remainder", 32'(remainder), 32'd0);

        // Reset between edges 2 and 3 of a running 6/4.
        applyStimulus(4'd6, 4'd4);
        tick;
        start = 1'b0;
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort quotient", 32'(quotient), 32'd0);
        checkOutput("abort remainder", 32'(remainder), 32'd0);
        checkOutput("abort dbz", 32'(div_by_zero), 32'd0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            tick;
            checkOutput("abort no done", 32'(done), 32'd0);
        end
        runDivide("6/4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b1);

        // Every operand pair against the arithmetic definition.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF;
                    er = W'(a);
                    ez = 1'b1;
                end else begin
                    eq = W'(a / b);
                    er = W'(a % b);
                    ez = 1'b0;
                end
                runDivide($sformatf("sweep %0d/%0d", a, b), W'(a), W'(b), eq, er, ez, 1'b0);
            end
        end
        start = 1'b0;
        tick;

        // WIDTH=8 build: 200/7.
        start8    = 1'b1;
        dividend8 = 8'd200;
        divisor8  = 8'd7;
        tick;
        start8 = 1'b0;
        checkOutput("w8 busy", 32'(busy8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick;
        end
        checkOutput("w8 done", 32'(done8), 32'd1);
        checkOutput("w8 quotient", 32'(quotient8), 32'd28);
        checkOutput("w8 remainder", 32'(remainder8), 32'd4);
        checkOutput("w8 dbz", 32'(div_by_zero8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
